// File: rtl/wave_pkg.sv
// Shared constants, channel state and read-address helper for the waveform capture buffer.
package wave_pkg;

  localparam int unsigned NPTS  = 320;
  localparam int unsigned PT_W  = 12;
  localparam int unsigned AW    = $clog2(NPTS);
  localparam int unsigned CNT_W = $clog2(NPTS + 1);

  localparam logic [11:0] CH0_BASE = 12'h559;
  localparam logic [11:0] CH1_BASE = 12'h6AD;
  localparam logic [11:0] MIDSCALE = 12'h800;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } ch_state_e;

  // Map a display index to a RAM word; once full, index 0 is the oldest point (at wr_ptr).
  function automatic logic [AW-1:0] phys_addr(input logic [AW-1:0] wr_ptr,
                                              input logic [AW-1:0] idx,
                                              input logic          full);
    logic [12:0] sum;
    sum = 13'(wr_ptr) + 13'(idx);
    if (sum >= 13'(NPTS)) sum = sum - 13'(NPTS);
    return full ? AW'(sum) : idx;
  endfunction

endpackage

// File: rtl/wave_ram.sv
// Simple dual-port point store: one write port, one registered read-first read port.
module wave_ram
  import wave_pkg::*;
(
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [PT_W-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [PT_W-1:0] rdata_o
);

  logic [PT_W-1:0] mem_q [NPTS];
  logic [PT_W-1:0] rdata_q;

  // Write and read in the same block so a same-address access returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wave_capture_buffer.sv
// Two-channel decimating rolling sample store feeding the VGA plotter read port.
// Optional build macro WAVE_PEAK_HOLD_EN: store the window maximum instead of the last sample.
module wave_capture_buffer
  import wave_pkg::*;
#(
  parameter int unsigned DECIM = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        sample_chan,
  input  logic [11:0] sample_data,
  input  logic        freeze,
  input  logic [11:0] sig_addr,
  output logic [31:0] sig_data,
  output logic [1:0]  buf_full
);

  localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

  logic            active_q;
  logic [7:0]      decim_cnt_q [2];
  logic [AW-1:0]   wr_ptr_q    [2];
  logic [CNT_W-1:0] fill_cnt_q [2];
  ch_state_e       state_q     [2];

  logic            xfer;
  logic [1:0]      hit_ch;
  logic [1:0]      store;
  logic [PT_W-1:0] store_data [2];

  // Accept when out of reset and not frozen.
  assign sample_ready = active_q && !freeze;
  assign xfer         = sample_valid && sample_ready;

  // Per-channel transfer and point-store strobes.
  always_comb begin
    hit_ch = '0;
    store  = '0;
    for (int c = 0; c < 2; c++) begin
      hit_ch[c] = xfer && (sample_chan == 1'(c));
      store[c]  = hit_ch[c] && (decim_cnt_q[c] == DECIM_LAST);
    end
  end

`ifdef WAVE_PEAK_HOLD_EN
  logic [PT_W-1:0] peak_q    [2];
  logic [PT_W-1:0] peak_next [2];

  // Running max including the current sample.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      peak_next[c]  = (sample_data > peak_q[c]) ? sample_data : peak_q[c];
      store_data[c] = peak_next[c];
    end
  end

  // Window max register, cleared when the window's point is stored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) peak_q[c] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (store[c])       peak_q[c] <= '0;
        else if (hit_ch[c]) peak_q[c] <= peak_next[c];
      end
    end
  end
`else
  // Last-sample decimation: the closing sample of the window is stored.
  always_comb begin
    for (int c = 0; c < 2; c++) store_data[c] = sample_data;
  end
`endif

  // Ready qualifier, decimation counters, write pointers, fill counters and channel FSMs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        decim_cnt_q[c] <= '0;
        wr_ptr_q[c]    <= '0;
        fill_cnt_q[c]  <= '0;
        state_q[c]     <= EMPTY;
      end
    end else begin
      active_q <= 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (hit_ch[c]) decim_cnt_q[c] <= store[c] ? 8'd0 : decim_cnt_q[c] + 8'd1;
        if (store[c]) begin
          wr_ptr_q[c] <= (wr_ptr_q[c] == AW'(NPTS - 1)) ? '0 : wr_ptr_q[c] + AW'(1);
          if (fill_cnt_q[c] != CNT_W'(NPTS)) fill_cnt_q[c] <= fill_cnt_q[c] + CNT_W'(1);
          case (state_q[c])
            EMPTY, FILLING:
              state_q[c] <= (fill_cnt_q[c] == CNT_W'(NPTS - 1)) ? FULL : FILLING;
            default:
              state_q[c] <= state_q[c];
          endcase
        end
      end
    end
  end

  assign buf_full = {state_q[1] == FULL, state_q[0] == FULL};

  // Read-side window decode and physical address, from this cycle's address and pointers.
  logic [12:0]   off0, off1;
  logic          win0, win1, rd_hit, rd_chan, rd_mask;
  logic [AW-1:0] rd_idx, rd_phys;

  always_comb begin
    off0    = 13'(sig_addr) - 13'(CH0_BASE);
    off1    = 13'(sig_addr) - 13'(CH1_BASE);
    win0    = (sig_addr >= CH0_BASE) && (off0 < 13'(NPTS));
    win1    = (sig_addr >= CH1_BASE) && (off1 < 13'(NPTS));
    rd_hit  = win0 || win1;
    rd_chan = win1;
    rd_idx  = win1 ? AW'(off1) : AW'(off0);
    rd_mask = (state_q[rd_chan] != FULL) && (CNT_W'(rd_idx) >= fill_cnt_q[rd_chan]);
    rd_phys = phys_addr(wr_ptr_q[rd_chan], rd_idx, state_q[rd_chan] == FULL);
  end

  logic hit_q, chan_q, mask_q;

  // Read-side qualifiers aligned with the RAM's registered output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_q  <= 1'b0;
      chan_q <= 1'b0;
      mask_q <= 1'b0;
    end else begin
      hit_q  <= rd_hit;
      chan_q <= rd_chan;
      mask_q <= rd_mask;
    end
  end

  logic [PT_W-1:0] rdata0, rdata1;

  wave_ram u_ram0 (
    .clk_i   (clock),
    .we_i    (store[0]),
    .waddr_i (wr_ptr_q[0]),
    .wdata_i (store_data[0]),
    .raddr_i (rd_phys),
    .rdata_o (rdata0)
  );

  wave_ram u_ram1 (
    .clk_i   (clock),
    .we_i    (store[1]),
    .waddr_i (wr_ptr_q[1]),
    .wdata_i (store_data[1]),
    .raddr_i (rd_phys),
    .rdata_o (rdata1)
  );

  // Output select from registered qualifiers and registered RAM data.
  always_comb begin
    sig_data = '0;
    if (hit_q) begin
      if (mask_q) sig_data = {20'b0, MIDSCALE};
      else        sig_data = {20'b0, chan_q ? rdata1 : rdata0};
    end
  end

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Directed self-checking bench for wave_capture_buffer (DECIM=4, NPTS=320).
module tb_wave_capture_buffer;

  logic        clock;
  logic        reset;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_chan;
  logic [11:0] sample_data;
  logic        freeze;
  logic [11:0] sig_addr;
  logic [31:0] sig_data;
  logic [1:0]  buf_full;

  int total = 0;
  int bad   = 0;

  wave_capture_buffer #(.DECIM(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_chan  (sample_chan),
    .sample_data  (sample_data),
    .freeze       (freeze),
    .sig_addr     (sig_addr),
    .sig_data     (sig_data),
    .buf_full     (buf_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present an address, return the data one clock later.
  task automatic do_read(input logic [11:0] a, output logic [31:0] got);
    sig_addr = a;
    @(posedge clock);
    #1;
    got = sig_data;
  endtask

  // One accepted sample on a channel.
  task automatic send(input logic ch, input logic [11:0] d);
    sample_valid = 1'b1;
    sample_chan  = ch;
    sample_data  = d;
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] got;
    #12;
    total++; if (sig_data !== 32'h0) begin bad++; $display("FAIL rst_sig_data got=%h exp=%h", sig_data, 32'h0); end
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", sample_ready); end
    total++; if (buf_full !== 2'b00) begin bad++; $display("FAIL rst_buf_full got=%b exp=00", buf_full); end
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b exp=0", sample_ready); end
    @(posedge clock); #1;
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b exp=1", sample_ready); end
    do_read(12'h559, got);
    total++; if (got !== 32'h800) begin bad++; $display("FAIL rst_rd_ch0 got=%h exp=%h", got, 32'h800); end
    do_read(12'h6AD, got);
    total++; if (got !== 32'h800) begin bad++; $display("FAIL rst_rd_ch1 got=%h exp=%h", got, 32'h800); end
  endtask

  task automatic test_decim;
    logic [31:0] got;
    for (int i = 0; i < 8; i++) send(1'b0, 12'h100 + 12'(i));
    do_read(12'h559, got);
    total++; if (got !== 32'h103) begin bad++; $display("FAIL decim_pt0 got=%h exp=%h", got, 32'h103); end
    do_read(12'h55A, got);
    total++; if (got !== 32'h107) begin bad++; $display("FAIL decim_pt1 got=%h exp=%h", got, 32'h107); end
    do_read(12'h55B, got);
    total++; if (got !== 32'h800) begin bad++; $display("FAIL decim_unwritten got=%h exp=%h", got, 32'h800); end
  endtask

  task automatic test_wrap;
    logic [31:0] got;
    for (int p = 0; p < 330; p++) begin
      for (int k = 0; k < 4; k++) send(1'b1, 12'(p));
      if (p == 318) begin
        total++; if (buf_full !== 2'b00) begin bad++; $display("FAIL full_at_319 got=%b exp=00", buf_full); end
      end
      if (p == 319) begin
        total++; if (buf_full !== 2'b10) begin bad++; $display("FAIL full_at_320 got=%b exp=10", buf_full); end
      end
    end
    total++; if (buf_full !== 2'b10) begin bad++; $display("FAIL full_at_330 got=%b exp=10", buf_full); end
    do_read(12'h6AD, got);
    total++; if (got !== 32'd10) begin bad++; $display("FAIL wrap_oldest got=%h exp=%h", got, 32'd10); end
    do_read(12'h6AE, got);
    total++; if (got !== 32'd11) begin bad++; $display("FAIL wrap_idx1 got=%h exp=%h", got, 32'd11); end
    do_read(12'h6AD + 12'd309, got);
    total++; if (got !== 32'd319) begin bad++; $display("FAIL wrap_idx309 got=%h exp=%h", got, 32'd319); end
    do_read(12'h6AD + 12'd310, got);
    total++; if (got !== 32'd320) begin bad++; $display("FAIL wrap_idx310 got=%h exp=%h", got, 32'd320); end
    do_read(12'h6AD + 12'd319, got);
    total++; if (got !== 32'd329) begin bad++; $display("FAIL wrap_newest got=%h exp=%h", got, 32'd329); end
  endtask

  task automatic test_freeze;
    logic [31:0] got;
    send(1'b0, 12'h200);
    send(1'b0, 12'h201);
    freeze = 1'b1;
    #1;
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL freeze_ready got=%b exp=0", sample_ready); end
    sample_valid = 1'b1;
    sample_chan  = 1'b0;
    sample_data  = 12'h2AA;
    repeat (3) @(posedge clock);
    #1;
    sample_valid = 1'b0;
    do_read(12'h559, got);
    total++; if (got !== 32'h103) begin bad++; $display("FAIL freeze_pt0 got=%h exp=%h", got, 32'h103); end
    do_read(12'h55B, got);
    total++; if (got !== 32'h800) begin bad++; $display("FAIL freeze_pt2_held got=%h exp=%h", got, 32'h800); end
    freeze = 1'b0;
    #1;
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL unfreeze_ready got=%b exp=1", sample_ready); end
    send(1'b0, 12'h202);
    do_read(12'h55B, got);
    total++; if (got !== 32'h800) begin bad++; $display("FAIL freeze_3of4 got=%h exp=%h", got, 32'h800); end
    send(1'b0, 12'h203);
    do_read(12'h55B, got);
    total++; if (got !== 32'h203) begin bad++; $display("FAIL freeze_pt2 got=%h exp=%h", got, 32'h203); end
    do_read(12'h55C, got);
    total++; if (got !== 32'h800) begin bad++; $display("FAIL freeze_pt3 got=%h exp=%h", got, 32'h800); end
  endtask

  task automatic test_out_of_window;
    logic [31:0] got;
    do_read(12'h558, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL oow_558 got=%h exp=0", got); end
    do_read(12'h699, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL oow_699 got=%h exp=0", got); end
    do_read(12'h7ED, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL oow_7ED got=%h exp=0", got); end
    do_read(12'hFFF, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL oow_FFF got=%h exp=0", got); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] addr [7];
    logic [31:0] exp  [7];
    addr = '{12'h559, 12'h699, 12'h55A, 12'h6AD, 12'h55B, 12'h55C, 12'h7EC};
    exp  = '{32'h103, 32'h0, 32'h107, 32'd10, 32'h203, 32'h800, 32'd329};
    sig_addr = addr[0];
    for (int i = 0; i < 7; i++) begin
      @(posedge clock);
      #1;
      total++;
      if (sig_data !== exp[i]) begin
        bad++;
        $display("FAIL b2b_%0d addr=%h got=%h exp=%h", i, addr[i], sig_data, exp[i]);
      end
      if (i < 6) sig_addr = addr[i + 1];
    end
  endtask

  task automatic test_read_first;
    logic [31:0] got;
    for (int k = 0; k < 3; k++) send(1'b1, 12'd500);
    sample_valid = 1'b1;
    sample_chan  = 1'b1;
    sample_data  = 12'd500;
    sig_addr     = 12'h6AD;
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    total++; if (sig_data !== 32'd10) begin bad++; $display("FAIL read_first got=%h exp=%h", sig_data, 32'd10); end
    do_read(12'h6AD, got);
    total++; if (got !== 32'd11) begin bad++; $display("FAIL rf_new_oldest got=%h exp=%h", got, 32'd11); end
    do_read(12'h7EC, got);
    total++; if (got !== 32'd500) begin bad++; $display("FAIL rf_newest got=%h exp=%h", got, 32'd500); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got;
    logic [31:0] peak_exp;
    sig_addr = 12'h559;
    @(posedge clock);
    #1;
    total++; if (sig_data !== 32'h103) begin bad++; $display("FAIL mid_pre got=%h exp=%h", sig_data, 32'h103); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (sig_data !== 32'h0) begin bad++; $display("FAIL mid_rst_sig_data got=%h exp=0", sig_data); end
    total++; if (buf_full !== 2'b00) begin bad++; $display("FAIL mid_rst_buf_full got=%b exp=00", buf_full); end
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", sample_ready); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    do_read(12'h559, got);
    total++; if (got !== 32'h800) begin bad++; $display("FAIL mid_rd_ch0 got=%h exp=%h", got, 32'h800); end
    do_read(12'h6AD, got);
    total++; if (got !== 32'h800) begin bad++; $display("FAIL mid_rd_ch1 got=%h exp=%h", got, 32'h800); end
    send(1'b0, 12'd5);
    send(1'b0, 12'd900);
    send(1'b0, 12'd3);
    send(1'b0, 12'd7);
`ifdef WAVE_PEAK_HOLD_EN
    peak_exp = 32'd900;
`else
    peak_exp = 32'd7;
`endif
    do_read(12'h559, got);
    total++; if (got !== peak_exp) begin bad++; $display("FAIL window_store got=%h exp=%h", got, peak_exp); end
    do_read(12'h55A, got);
    total++; if (got !== 32'h800) begin bad++; $display("FAIL window_next got=%h exp=%h", got, 32'h800); end
  endtask

  initial begin
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_chan  = 1'b0;
    sample_data  = '0;
    freeze       = 1'b0;
    sig_addr     = 12'h559;
    test_reset();
    test_decim();
    test_wrap();
    test_freeze();
    test_out_of_window();
    test_back_to_back();
    test_read_first();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_capture_buffer.md
Name: wave_capture_buffer

Overview:
Two-channel rolling sample store that feeds the VGA waveform plotter's signal-memory read port. Accepts 12-bit ADC samples (channel 0 = ECG, channel 1 = EMG) over a valid/ready handshake and decimates each channel by DECIM. Keeps the latest NPTS points per channel in circular RAM. Serves the plotter's address/data port so that display index 0 is always the oldest point, giving a left-scrolling trace.

Parameters:
NPTS, 320, points stored and displayed per channel.
DECIM, 4, accepted samples per channel collapsed into one stored point (1..256).
CH0_BASE, 12'h559, first plotter address of channel 0 window.
CH1_BASE, 12'h6AD, first plotter address of channel 1 window.
MIDSCALE, 12'h800, value returned for points not yet written.

Ports:
clock  in  1  system clock (100 MHz domain, same as plotter RAM reads).
reset  in  1  asynchronous, active-low reset (asserted when 0).
sample_valid  in  1  sample_data/sample_chan valid.
sample_ready  out  1  block accepts the sample this cycle.
sample_chan  in  1  0 = ECG, 1 = EMG.
sample_data  in  12  unsigned ADC code.
freeze  in  1  hold display contents; stop accepting samples.
sig_addr  in  12  plotter read address.
sig_data  out  32  {20'b0, point}; valid 1 cycle after sig_addr.
buf_full  out  2  per-channel: NPTS points have been written since reset.

Behaviour:
- Reset (reset=0, async): wr_ptr[c]=0, decim_cnt[c]=0, fill_cnt[c]=0, buf_full=0, sig_data=0, sample_ready=0; the FSM enters EMPTY. RAM contents are not cleared; fill_cnt masks them.
- sample_ready = !freeze && !reset-state, registered for one cycle after reset deassertion. A transfer occurs when sample_valid && sample_ready.
- Per-channel FSM: EMPTY -> FILLING on the first stored point; FILLING -> FULL when fill_cnt reaches NPTS. FULL persists until reset. buf_full[c] = (state==FULL).
- Decimation: each transfer on channel c increments decim_cnt[c]. When decim_cnt[c]==DECIM-1, the point is written to RAM[c][wr_ptr[c]] on the next clock and decim_cnt[c] returns to 0. The stored value is the sample at that transfer.
- wr_ptr[c] increments mod NPTS (NPTS-1 -> 0) per stored point. fill_cnt[c] saturates at NPTS.
- Read map: if CH0_BASE <= sig_addr < CH0_BASE+NPTS, then c=0 and idx=sig_addr-CH0_BASE; the same rule applies to CH1. Any other address returns sig_data=0.
- Physical address = wr_ptr[c]+idx when FULL; subtract NPTS if the sum >= NPTS (13-bit intermediate, no wrap beyond). In FILLING/EMPTY the physical address is idx, and idx >= fill_cnt[c] returns MIDSCALE.
- Read latency: exactly 1 clock, with registered sig_data. Window decode and the wr_ptr snapshot are taken in the same cycle as the address.
- Simultaneous write and read of the same RAM word: the read returns the old data (read-first).
- freeze mid-decimation: decim_cnt holds its value and resumes when freeze drops. The display is static while freeze=1.
- Reset mid-operation: all state is cleared immediately. Reads then return MIDSCALE for in-window addresses.

Optional Feature:
Macro WAVE_PEAK_HOLD_EN.
- Defined: each channel keeps a running max over the DECIM-sample window (reset to 0 at window start). The max is stored instead of the last sample, so narrow EMG spikes are preserved.
- Undefined: last-sample decimation as above, and no max registers are synthesized.

Decomposition:
- Shared package wave_pkg: NPTS, CH0_BASE, CH1_BASE, MIDSCALE, the channel-state enum (EMPTY, FILLING, FULL), and the point width (12).
- Sub-module wave_ram: simple dual-port, NPTS x 12, one write port, one registered read-first port; instantiated once per channel.

Test Plan:
1. Reset, then read 12'h559 and 12'h6AD -> sig_data=32'h800 one cycle later; buf_full=2'b00.
2. DECIM=4: send 8 ch0 samples 0x100..0x107 -> RAM ch0 points 0x103 and 0x107; read 12'h559 -> 0x103, read 12'h55A -> 0x107, read 12'h55B -> 0x800.
3. Send 330 points to ch1 (values = point index) -> buf_full[1]=1, wr_ptr=10; read 12'h6AD -> 10, read 12'h6AD+319 -> 329 (wrap check).
4. Assert freeze after 2 of 4 ch0 samples -> sample_ready=0 and contents unchanged; release, send 2 more -> exactly one point stored.
5. Read 12'h558, 12'h699, 12'hFFF -> 0; back-to-back addresses stream one result per cycle at 1-cycle latency.
6. Pull reset low mid-stream -> outputs clear asynchronously, with no clock edge required; with WAVE_PEAK_HOLD_EN, window 5,900,3,7 -> stored 900.
